// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data_ram between the core (port 0)
// and a loader/debug master (port 1), with burst lock and tagged read return.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_port_q, pend_port_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic arb_en;
    logic gnt_any;
    logic gnt_port;
    logic gnt_we;
    logic gnt_lock;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = ARB;
        rr_last_d    = rr_last_q;
        pend_valid_d = 1'b0;
        pend_port_d  = pend_port_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        arb_en       = 1'b0;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;

        // An owner that drops req hands the cycle back to normal arbitration.
        unique case (state_q)
            OWN0: begin
                if (m0_req) m0_gnt = 1'b1;
                else        arb_en = 1'b1;
            end
            OWN1: begin
                if (m1_req) m1_gnt = 1'b1;
                else        arb_en = 1'b1;
            end
            default: arb_en = 1'b1;
        endcase

        if (arb_en) begin
            if (m0_req && m1_req) begin
                m0_gnt = rr_last_q;
                m1_gnt = ~rr_last_q;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end

        if (rst) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end

        gnt_any  = m0_gnt | m1_gnt;
        gnt_port = m1_gnt;
        gnt_we   = m1_gnt ? m1_we   : m0_we;
        gnt_lock = m1_gnt ? m1_lock : m0_lock;

        if (gnt_any) begin
            rr_last_d    = gnt_port;
            pend_valid_d = ~gnt_we;
            pend_port_d  = gnt_port;
            addr_d       = m1_gnt ? m1_addr  : m0_addr;
            wdata_d      = m1_gnt ? m1_wdata : m0_wdata;
            if (gnt_lock) state_d = gnt_port ? OWN1 : OWN0;
        end

        mem_en    = gnt_any;
        mem_we    = {4{gnt_any & gnt_we}};
        mem_addr  = rst ? '0 : addr_d;
        mem_wdata = rst ? '0 : wdata_d;

        m0_rvalid = pend_valid_q & ~pend_port_q & ~rst;
        m1_rvalid = pend_valid_q &  pend_port_q & ~rst;
        m0_rdata  = rst ? '0 : (m0_rvalid ? mem_rdata : rdata0_q);
        m1_rdata  = rst ? '0 : (m1_rvalid ? mem_rdata : rdata1_q);
        rdata0_d  = m0_rdata;
        rdata1_d  = m1_rdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            rr_last_q    <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_port_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            pend_valid_q <= pend_valid_d;
            pend_port_q  <= pend_port_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small registered BRAM model behind it.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [0:255];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port BRAM with registered output
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr[7:0]];
            if (|mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'hDEADBEEF;
        ram[8'h14] = 32'h12345678;
        mem_rdata = 32'h0;
        rst = 1'b1;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        tick(); tick();

        // Reset state, with requests present to show they are masked
        set_m0(1, 0, 32'h10, 0, 0);
        #2;
        check("rst_m0_gnt", {31'b0, m0_gnt}, 0);
        check("rst_mem_en", {31'b0, mem_en}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        tick();

        // Test 1: single read
        rst = 1'b0;
        #2;
        check("t1_m0_gnt", {31'b0, m0_gnt}, 1);
        check("t1_m1_gnt", {31'b0, m1_gnt}, 0);
        check("t1_mem_en", {31'b0, mem_en}, 1);
        check("t1_mem_we", {28'b0, mem_we}, 0);
        check("t1_mem_addr", mem_addr, 32'h10);
        tick();
        set_m0(0, 0, 0, 0, 0);
        #2;
        check("t1_m0_rvalid", {31'b0, m0_rvalid}, 1);
        check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("t1_m1_rvalid", {31'b0, m1_rvalid}, 0);
        check("t1_idle_en", {31'b0, mem_en}, 0);
        check("t1_addr_hold", mem_addr, 32'h10);
        tick();
        #2;
        check("t1_rvalid_drop", {31'b0, m0_rvalid}, 0);
        check("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // Test 2: continuous contention from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_m0(1, 0, 32'h10, 0, 0);
        set_m1(1, 0, 32'h14, 0, 0);
        for (int i = 0; i < 6; i++) begin
            #2;
            check($sformatf("t2_m0_gnt%0d", i), {31'b0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t2_m1_gnt%0d", i), {31'b0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("t2_m0_rv%0d", i), {31'b0, m0_rvalid}, (i > 0 && i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("t2_m1_rv%0d", i), {31'b0, m1_rvalid}, (i > 0 && i % 2 == 0) ? 32'd1 : 32'd0);
            if (i > 0 && i % 2 == 1) check($sformatf("t2_m0_rd%0d", i), m0_rdata, 32'hDEADBEEF);
            if (i > 0 && i % 2 == 0) check($sformatf("t2_m1_rd%0d", i), m1_rdata, 32'h12345678);
            tick();
        end

        // Test 3: locked write burst from m1 while m0 waits
        set_m0(0, 0, 0, 0, 0);
        set_m1(1, 1, 32'h20, 32'hAA, 1);
        #2;
        check("t3_m1_gnt0", {31'b0, m1_gnt}, 1);
        check("t3_mem_we0", {28'b0, mem_we}, 32'hF);
        check("t3_m1_rv_overlap", {31'b0, m1_rvalid}, 1);
        check("t3_m1_rd_overlap", m1_rdata, 32'h12345678);
        tick();
        set_m0(1, 0, 32'h20, 0, 0);
        for (int j = 1; j < 4; j++) begin
            m1_lock = (j < 3);
            #2;
            check($sformatf("t3_m1_gnt%0d", j), {31'b0, m1_gnt}, 1);
            check($sformatf("t3_m0_gnt%0d", j), {31'b0, m0_gnt}, 0);
            check($sformatf("t3_mem_we%0d", j), {28'b0, mem_we}, 32'hF);
            check($sformatf("t3_wdata%0d", j), mem_wdata, 32'hAA);
            tick();
        end
        set_m1(0, 0, 0, 0, 0);
        #2;
        check("t3_m0_gnt_after", {31'b0, m0_gnt}, 1);
        check("t3_m1_gnt_after", {31'b0, m1_gnt}, 0);
        tick();

        // Test 4: read back the written word
        set_m0(0, 0, 0, 0, 0);
        #2;
        check("t4_m0_rvalid", {31'b0, m0_rvalid}, 1);
        check("t4_m0_rdata", m0_rdata, 32'hAA);
        check("t4_m1_rvalid", {31'b0, m1_rvalid}, 0);
        tick();

        // Test 5: reset while m1 owns the lock with a read in flight
        set_m1(1, 0, 32'h14, 0, 1);
        #2;
        check("t5_m1_gnt", {31'b0, m1_gnt}, 1);
        tick();
        rst = 1'b1;
        set_m0(1, 0, 32'h10, 0, 0);
        #2;
        check("t5_rst_m1_rv", {31'b0, m1_rvalid}, 0);
        check("t5_rst_gnt", {30'b0, m0_gnt, m1_gnt}, 0);
        check("t5_rst_en", {31'b0, mem_en}, 0);
        check("t5_rst_we", {28'b0, mem_we}, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_wdata", mem_wdata, 0);
        check("t5_rst_m0_rd", m0_rdata, 0);
        check("t5_rst_m1_rd", m1_rdata, 0);
        tick();
        rst = 1'b0;
        m1_lock = 1'b0;
        #2;
        check("t5_post_m1_rv", {31'b0, m1_rvalid}, 0);
        check("t5_tie_m0", {31'b0, m0_gnt}, 1);
        check("t5_tie_m1", {31'b0, m1_gnt}, 0);
        tick();

        // Test 6: owner drops req, other port granted in that cycle
        set_m0(1, 0, 32'h10, 0, 1);
        set_m1(0, 0, 0, 0, 0);
        #2;
        check("t6_m0_gnt_a", {31'b0, m0_gnt}, 1);
        check("t6_m0_rv_a", {31'b0, m0_rvalid}, 1);
        tick();
        set_m1(1, 0, 32'h14, 0, 0);
        #2;
        check("t6_m0_gnt_b", {31'b0, m0_gnt}, 1);
        check("t6_m1_gnt_b", {31'b0, m1_gnt}, 0);
        tick();
        m0_req = 1'b0;
        #2;
        check("t6_m1_gnt_c", {31'b0, m1_gnt}, 1);
        check("t6_m0_gnt_c", {31'b0, m0_gnt}, 0);
        tick();
        set_m0(1, 0, 32'h10, 0, 0);
        #2;
        check("t6_arb_m0_d", {31'b0, m0_gnt}, 1);
        check("t6_arb_m1_d", {31'b0, m1_gnt}, 0);
        check("t6_m1_rv_d", {31'b0, m1_rvalid}, 1);
        check("t6_m1_rd_d", m1_rdata, 32'h12345678);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data_ram between two requesters: port 0 is the riscv core load/store path, port 1 is a loader/debug master that fills or inspects data memory.
- Sits between the requesters and data_ram's ena/wea/addra/dina/douta pins.
- Grants at most one access per cycle using round-robin arbitration, with an optional lock so one master can own memory for a burst.
- Routes the one-cycle-latency BRAM read data back to the requester that issued the read.

Parameters:
- DATA_WIDTH, 32, width of data words and of mem_wdata/mem_rdata.
- ADDR_WIDTH, 32, width of request and memory addresses.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- m0_req  input  1  port 0 access request; held until granted.
- m0_we  input  1  port 0 write (1) or read (0).
- m0_addr  input  ADDR_WIDTH  port 0 address.
- m0_wdata  input  DATA_WIDTH  port 0 write data.
- m0_lock  input  1  port 0 requests to keep ownership after this grant.
- m0_gnt  output  1  port 0 access accepted this cycle.
- m0_rvalid  output  1  port 0 read data valid.
- m0_rdata  output  DATA_WIDTH  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same definitions, for port 1.
- mem_en  output  1  to data_ram ena.
- mem_we  output  4  to data_ram wea; all four bits equal the granted we.
- mem_addr  output  ADDR_WIDTH  to data_ram addra.
- mem_wdata  output  DATA_WIDTH  to data_ram dina.
- mem_rdata  input  DATA_WIDTH  from data_ram douta; registered, valid one cycle after a read issue.

Behaviour:
- FSM states:
  - ARB: round-robin arbitration.
  - OWN0: port 0 holds the lock.
  - OWN1: port 1 holds the lock.
- Reset:
  - state=ARB and rr_last=1, so port 0 wins the first tie.
  - Pending-read tag is cleared.
  - All outputs are 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata.
- ARB state:
  - Only one req asserted: grant it.
  - Both asserted: grant the port that is not rr_last.
  - On any grant, rr_last <= granted port.
  - If the granted port also has lock=1, next state is OWN<port>.
- OWNn state:
  - Only port n can be granted; the other port's req is ignored and waits.
  - Stay in OWNn while port n asserts req with lock=1.
  - Return to ARB when a grant to port n carries lock=0, or when port n deasserts req in a cycle (no grant that cycle).
- Grant timing:
  - gnt is combinational, in the same cycle as req.
  - mem_en=1 and mem_addr/mem_wdata/mem_we are driven combinationally from the granted port in that cycle.
  - No grant: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last granted values (registered copy).
- Reads:
  - A granted read (we=0) sets pend_valid<=1 and pend_port<=granted port.
  - In the next cycle, m<pend_port>_rvalid=1 and m<pend_port>_rdata=mem_rdata, passed combinationally from the registered BRAM output.
  - Read latency is 1 cycle after gnt.
  - Back-to-back reads at full throughput are allowed, including alternating ports; each return is routed by its own tag.
  - m*_rdata holds its last value when rvalid=0.
- Writes:
  - Complete on the granted cycle; no rvalid.
  - A read and a write to the same address in consecutive cycles see BRAM read-first/write-first per the data_ram configuration. The arbiter adds no forwarding.
- Simultaneous events: a new grant and the previous read's rvalid may coincide in the same cycle; both occur.
- rst asserted mid-operation:
  - Any pending read return is discarded; rvalid stays 0 in the cycle after reset.
  - A held lock is released.
- Fairness: with both ports requesting continuously and no lock, grants alternate 0,1,0,1,... No port waits more than 1 cycle unless the other port holds the lock.

Test Plan:
1. Reset, then m0_req=1 read addr 0x10 with data_ram[0x10]=0xDEADBEEF -> m0_gnt=1, mem_en=1, mem_we=0 in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1_rvalid stays 0.
2. Both ports request reads continuously for 6 cycles -> grant sequence 0,1,0,1,0,1; each rvalid arrives 1 cycle after its grant, tagged to the correct port.
3. m1 writes 0x000000AA to 0x20 with lock=1 for 4 writes while m0_req=1 -> m1 is granted 4 consecutive cycles, mem_we=4'b1111 on each, m0_gnt=0; on the 4th write (lock=0) m0 is granted the next cycle.
4. m0 reads 0x20 after test 3 -> m0_rdata=0x000000AA one cycle after grant.
5. Read granted in cycle k, rst=1 in cycle k+1 -> no rvalid in k+1 or later; all outputs 0; state is ARB, and the first tie afterwards goes to m0.
6. m0 holds lock, then drops req for one cycle while m1_req=1 -> state returns to ARB and m1 is granted in that same cycle.
